// File: rtl/simon_round_controller.sv
// Simon Says round sequencer: draws a 4-arrow sequence from an LFSR, hands it to
// playback, then scores the player's presses with a per-press timeout.
module simon_round_controller #(
    parameter logic [7:0] SEED       = 8'hA5,
    parameter int         NUM_ROUNDS = 4,
    parameter int         TIMEOUT    = 1000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_dir,
    input  logic       play_done,
    output logic [7:0] arrow_seq,
    output logic       play_begin,
    output logic [3:0] round,
    output logic       busy,
    output logic       win,
    output logic       lose
);

    localparam int              TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]      R_LAST = 4'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_INPUT,
        S_WIN,
        S_LOSE
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    lfsr;
    logic [7:0]    seq_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [3:0]    round_nxt;
    logic          play_begin_nxt, busy_nxt, win_nxt, lose_nxt;
    logic [1:0]    want_dir;

    // x^8+x^6+x^5+x^4+1; the all-zero state is unreachable from a non-zero seed
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Arrow 0 lives in the top bits, so shift the wanted arrow up to [7:6]
    function automatic logic [1:0] arrow_at(input logic [7:0] s, input logic [1:0] i);
        logic [7:0] sh;
        sh = s << {i, 1'b0};
        return sh[7:6];
    endfunction

    assign want_dir = arrow_at(arrow_seq, idx);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        seq_nxt   = arrow_seq;
        idx_nxt   = idx;
        timer_nxt = timer;
        round_nxt = round;
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    round_nxt = '0;
                end
            end
            S_LOAD: begin
                // Waiting out play_done lets the playback unit re-arm between rounds
                if (!play_done) begin
                    seq_nxt   = lfsr;
                    state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (play_done) begin
                    state_nxt = S_INPUT;
                    idx_nxt   = '0;
                    timer_nxt = '0;
                end
            end
            S_INPUT: begin
                // A press always wins over a timeout landing in the same cycle
                if (btn_valid) begin
                    if (btn_dir == want_dir) begin
                        timer_nxt = '0;
                        if (idx == 2'd3) begin
                            round_nxt = round + 4'd1;
                            state_nxt = (round == R_LAST) ? S_WIN : S_LOAD;
                        end else begin
                            idx_nxt = idx + 2'd1;
                        end
                    end else begin
                        state_nxt = S_LOSE;
                    end
                end else if (timer == T_LAST) begin
                    state_nxt = S_LOSE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        play_begin_nxt = (state_nxt == S_PLAY);
        busy_nxt       = (state_nxt inside {S_LOAD, S_PLAY, S_INPUT});
        win_nxt        = (state_nxt == S_WIN);
        lose_nxt       = (state_nxt == S_LOSE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr       <= SEED;
            arrow_seq  <= '0;
            idx        <= '0;
            timer      <= '0;
            round      <= '0;
            play_begin <= 1'b0;
            busy       <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            lfsr       <= lfsr_step(lfsr);
            arrow_seq  <= seq_nxt;
            idx        <= idx_nxt;
            timer      <= timer_nxt;
            round      <= round_nxt;
            play_begin <= play_begin_nxt;
            busy       <= busy_nxt;
            win        <= win_nxt;
            lose       <= lose_nxt;
        end
    end

endmodule
